// File: rtl/fib_write_checker.sv
// fib_write_checker
//
// Passive snoop checker for the 8-bit mipscpu_mem data-memory write port.
// Every CPU store is observed; stores landing in the result window
// [BASE_ADDR, BASE_ADDR+NUM_TERMS-1] are compared, in order, against an
// internally generated Fibonacci sequence (0, 1, 1, 2, ... modulo 256).
// This lets the Fibonacci program check itself on the board.
//
// Parameters:
//   BASE_ADDR  address of the first Fibonacci term
//   NUM_TERMS  number of terms expected, 1..(256-BASE_ADDR)
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous reset, active low
//   memwrite        store strobe, one cycle per store
//   adr             store address
//   writedata       store data
//   pass_count      in-window stores that matched (saturates at 255)
//   err_count       in-window stores that mismatched (saturates at 255)
//   done            all NUM_TERMS in-window stores have been checked
//   fail            sticky, set on the first mismatch
//   first_err_adr   adr of the first mismatching store
//   first_err_data  writedata of the first mismatching store
//   expected        Fibonacci value expected by the next in-window store
//
// Optional feature (macro FIB_CHECK_HALT_ON_ERR_EN):
//   When defined, the first mismatch moves the checker to a HALT state in
//   which counters, position and captures freeze and done stays low.
//   When undefined, checking continues through errors.

module fib_write_checker #(
    parameter logic [7:0] BASE_ADDR = 8'd128,
    parameter int         NUM_TERMS = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memwrite,
    input  logic [7:0] adr,
    input  logic [7:0] writedata,
    output logic [7:0] pass_count,
    output logic [7:0] err_count,
    output logic       done,
    output logic       fail,
    output logic [7:0] first_err_adr,
    output logic [7:0] first_err_data,
    output logic [7:0] expected
);

    // Nine-bit arithmetic so the window end and BASE_ADDR+idx never wrap.
    localparam logic [8:0] LAST_ADR = {1'b0, BASE_ADDR} + 9'(NUM_TERMS) - 9'd1;
    localparam logic [8:0] LAST_IDX = 9'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        CHECK = 2'd0,
        DONE  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [8:0] idx;
    logic [7:0] fib_a;
    logic [7:0] fib_b;

    logic       in_window;
    logic       match;
    logic       last_term;
    logic       check_store;
    logic       late_store;
    logic       flag_err;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CHECK;
        end else begin
            state <= state_next;
        end
    end

    // Store classification and next-state decision. A store is judged
    // purely by position: a wrong address still consumes a term.
    always_comb begin
        in_window   = memwrite
                      && ({1'b0, adr} >= {1'b0, BASE_ADDR})
                      && ({1'b0, adr} <= LAST_ADR);
        match       = ({1'b0, adr} == ({1'b0, BASE_ADDR} + idx))
                      && (writedata == fib_a);
        last_term   = (idx == LAST_IDX);
        check_store = in_window && (state == CHECK);
        late_store  = in_window && (state == DONE);
        flag_err    = (check_store && !match) || late_store;

        state_next = state;
        case (state)
            CHECK: begin
                if (in_window) begin
`ifdef FIB_CHECK_HALT_ON_ERR_EN
                    if (!match) begin
                        state_next = HALT;
                    end else if (last_term) begin
                        state_next = DONE;
                    end
`else
                    if (last_term) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            DONE:    state_next = DONE;
            HALT:    state_next = HALT;
            default: state_next = CHECK;
        endcase
    end

    // Datapath: sequence generator, counters and first-error capture.
    // expected only follows fib_a while more terms remain, so in DONE it
    // keeps showing the last term that was checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx            <= '0;
            fib_a          <= 8'd0;
            fib_b          <= 8'd1;
            pass_count     <= 8'd0;
            err_count      <= 8'd0;
            fail           <= 1'b0;
            first_err_adr  <= 8'd0;
            first_err_data <= 8'd0;
            expected       <= 8'd0;
        end else begin
            if (check_store) begin
                idx   <= idx + 9'd1;
                fib_a <= fib_b;
                fib_b <= fib_a + fib_b;
                if (match && (pass_count != 8'hFF)) begin
                    pass_count <= pass_count + 8'd1;
                end
                if (!last_term) begin
                    expected <= fib_b;
                end
            end
            if (flag_err) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (!fail) begin
                    fail           <= 1'b1;
                    first_err_adr  <= adr;
                    first_err_data <= writedata;
                end
            end
        end
    end

    assign done = (state == DONE);

endmodule
